// File: rtl/ibex_data_bus_bridge.sv
// Bridges the Ibex data port onto a valid/ready A/D bus, with a local error response for out-of-window accesses.
// Define IBEX_BRIDGE_RSP_REG_EN to register bus responses (1-cycle latency); otherwise they pass through combinationally.
module ibex_data_bus_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ADDR_BASE       = 32'h8000_0000,
  parameter logic [31:0] ADDR_MASK       = 32'hF000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        a_valid_o,
  input  logic        a_ready_i,
  output logic        a_we_o,
  output logic [3:0]  a_mask_o,
  output logic [31:0] a_addr_o,
  output logic [31:0] a_data_o,
  input  logic        d_valid_i,
  output logic        d_ready_o,
  input  logic [31:0] d_data_i,
  input  logic        d_error_i,
  output logic        err_unexpected_o
);

  localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, BUSY, LERR} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          in_window;
  logic          a_hs;
  logic          d_hs;
  logic          d_drop;
  logic          lerr_gnt;
  logic          bus_valid;
  logic          bus_err;
  logic [31:0]   bus_data;

  assign a_we_o   = data_we_i;
  assign a_mask_o = data_be_i;
  assign a_addr_o = data_addr_i;
  assign a_data_o = data_wdata_i;

  // Out-of-window requests are only granted from IDLE so their error response stays in order behind bus traffic.
  always_comb begin
    in_window  = (data_addr_i & ADDR_MASK) == ADDR_BASE;
    a_valid_o  = !rst_i && data_req_i && in_window && (state != LERR) && (cnt < MAX_CNT);
    a_hs       = a_valid_o && a_ready_i;
    lerr_gnt   = !rst_i && data_req_i && !in_window && (state == IDLE);
    data_gnt_o = a_hs || lerr_gnt;
    d_ready_o  = !rst_i && ((cnt != '0) || d_valid_i);
    d_hs       = d_valid_i && d_ready_o && (cnt != '0);
    d_drop     = d_valid_i && d_ready_o && (cnt == '0);
  end

  always_comb begin
    cnt_next = cnt;
    if (a_hs && !d_hs) begin
      cnt_next = cnt + CW'(1);
    end else if (!a_hs && d_hs) begin
      cnt_next = cnt - CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (lerr_gnt) begin
      state_next = LERR;
    end else if (cnt_next != '0) begin
      state_next = BUSY;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      err_unexpected_o <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (d_drop) begin
        err_unexpected_o <= 1'b1;
      end
    end
  end

`ifdef IBEX_BRIDGE_RSP_REG_EN
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= d_hs;
      rsp_err_q   <= d_hs && d_error_i;
      rsp_data_q  <= d_hs ? d_data_i : '0;
    end
  end

  assign bus_valid = rsp_valid_q;
  assign bus_err   = rsp_err_q;
  assign bus_data  = rsp_data_q;
`else
  assign bus_valid = d_hs;
  assign bus_err   = d_hs && d_error_i;
  assign bus_data  = d_hs ? d_data_i : '0;
`endif

  // LERR is only entered with nothing outstanding, so the two sources never collide; bus wins regardless.
  always_comb begin
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    data_rdata_o  = '0;
    if (bus_valid) begin
      data_rvalid_o = 1'b1;
      data_err_o    = bus_err;
      data_rdata_o  = bus_data;
    end else if (state == LERR) begin
      data_rvalid_o = 1'b1;
      data_err_o    = 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_data_bus_bridge.sv
// Directed bench for ibex_data_bus_bridge; follows IBEX_BRIDGE_RSP_REG_EN to pick the expected response latency.
module tb_ibex_data_bus_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        a_valid_o;
  logic        a_ready_i = 1'b0;
  logic        a_we_o;
  logic [3:0]  a_mask_o;
  logic [31:0] a_addr_o;
  logic [31:0] a_data_o;
  logic        d_valid_i = 1'b0;
  logic        d_ready_o;
  logic [31:0] d_data_i = '0;
  logic        d_error_i = 1'b0;
  logic        err_unexpected_o;

  int total = 0;
  int bad   = 0;

  ibex_data_bus_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_we_o(a_we_o), .a_mask_o(a_mask_o),
    .a_addr_o(a_addr_o), .a_data_o(a_data_o),
    .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_data_i(d_data_i), .d_error_i(d_error_i),
    .err_unexpected_o(err_unexpected_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic ready);
    data_req_i   = req;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    a_ready_i    = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one D beat and checks the core response at the configured latency; returns one cycle after the beat.
  task automatic respond(input logic [31:0] d, input logic e, input logic exp_gnt, input string tag);
    d_valid_i = 1'b1;
    d_data_i  = d;
    d_error_i = e;
    #1;
    checkOutput({tag, "_hs_gnt"}, {31'b0, data_gnt_o}, {31'b0, exp_gnt});
`ifdef IBEX_BRIDGE_RSP_REG_EN
    tick();
    d_valid_i = 1'b0;
    d_data_i  = '0;
    d_error_i = 1'b0;
    #1;
`endif
    checkOutput({tag, "_rvalid"}, {31'b0, data_rvalid_o}, 32'd1);
    checkOutput({tag, "_rdata"}, data_rdata_o, d);
    checkOutput({tag, "_err"}, {31'b0, data_err_o}, {31'b0, e});
`ifndef IBEX_BRIDGE_RSP_REG_EN
    tick();
    d_valid_i = 1'b0;
    d_data_i  = '0;
    d_error_i = 1'b0;
    #1;
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting");
    repeat (2) @(posedge clk_i);
    #1;
    d_valid_i = 1'b1;
    d_data_i  = 32'hA5A5_A5A5;
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0, 1'b1);
    checkOutput("rst_a_valid", {31'b0, a_valid_o}, 32'd0);
    checkOutput("rst_gnt", {31'b0, data_gnt_o}, 32'd0);
    checkOutput("rst_d_ready", {31'b0, d_ready_o}, 32'd0);
    checkOutput("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    checkOutput("rst_err", {31'b0, data_err_o}, 32'd0);
    checkOutput("rst_rdata", data_rdata_o, 32'd0);
    checkOutput("rst_sticky", {31'b0, err_unexpected_o}, 32'd0);
    rst_i     = 1'b0;
    d_valid_i = 1'b0;
    d_data_i  = '0;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("rst_d_ready_idle", {31'b0, d_ready_o}, 32'd0);

    // single read, response three cycles after grant
    tick();
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0010, 32'h0, 1'b1);
    checkOutput("t1_a_valid", {31'b0, a_valid_o}, 32'd1);
    checkOutput("t1_gnt", {31'b0, data_gnt_o}, 32'd1);
    checkOutput("t1_a_addr", a_addr_o, 32'h8000_0010);
    checkOutput("t1_a_we", {31'b0, a_we_o}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("t1_d_ready", {31'b0, d_ready_o}, 32'd1);
    tick();
    tick();
    respond(32'hDEAD_BEEF, 1'b0, 1'b0, "t1");
`ifndef IBEX_BRIDGE_RSP_REG_EN
    checkOutput("t1_rvalid_drop", {31'b0, data_rvalid_o}, 32'd0);
`endif
    tick();
    checkOutput("t1_idle_rvalid", {31'b0, data_rvalid_o}, 32'd0);

    // three back-to-back requests against a limit of two
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0100, 32'h0, 1'b1);
    checkOutput("t2_gnt0", {31'b0, data_gnt_o}, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0104, 32'h0, 1'b1);
    checkOutput("t2_gnt1", {31'b0, data_gnt_o}, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0108, 32'h0, 1'b1);
    checkOutput("t2_full_a_valid", {31'b0, a_valid_o}, 32'd0);
    checkOutput("t2_held0", {31'b0, data_gnt_o}, 32'd0);
    tick();
    checkOutput("t2_held1", {31'b0, data_gnt_o}, 32'd0);
    respond(32'h1111_1111, 1'b0, 1'b0, "t2_r0");
    checkOutput("t2_gnt2", {31'b0, data_gnt_o}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    respond(32'h2222_2222, 1'b0, 1'b0, "t2_r1");
    respond(32'h3333_3333, 1'b0, 1'b0, "t2_r2");
    tick();

    // out-of-window request behind one outstanding read
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0200, 32'h0, 1'b1);
    checkOutput("t3_gnt_in", {31'b0, data_gnt_o}, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 1'b1);
    checkOutput("t3_oow_a_valid", {31'b0, a_valid_o}, 32'd0);
    checkOutput("t3_oow_held0", {31'b0, data_gnt_o}, 32'd0);
    tick();
    checkOutput("t3_oow_held1", {31'b0, data_gnt_o}, 32'd0);
    respond(32'h4444_4444, 1'b0, 1'b0, "t3_r0");
    checkOutput("t3_oow_gnt", {31'b0, data_gnt_o}, 32'd1);
    checkOutput("t3_oow_a_valid2", {31'b0, a_valid_o}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("t3_lerr_rvalid", {31'b0, data_rvalid_o}, 32'd1);
    checkOutput("t3_lerr_err", {31'b0, data_err_o}, 32'd1);
    checkOutput("t3_lerr_rdata", data_rdata_o, 32'd0);
    checkOutput("t3_lerr_a_valid", {31'b0, a_valid_o}, 32'd0);
    tick();
    checkOutput("t3_lerr_done", {31'b0, data_rvalid_o}, 32'd0);

    // partial write answered with a bus error
    applyStimulus(1'b1, 1'b1, 4'b0011, 32'h8000_0300, 32'h1234_5678, 1'b1);
    checkOutput("t4_a_we", {31'b0, a_we_o}, 32'd1);
    checkOutput("t4_a_mask", {28'b0, a_mask_o}, 32'h3);
    checkOutput("t4_a_data", a_data_o, 32'h1234_5678);
    checkOutput("t4_gnt", {31'b0, data_gnt_o}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    respond(32'hCAFE_F00D, 1'b1, 1'b0, "t4");
    tick();

    // unexpected response with nothing outstanding
    checkOutput("t5_sticky_pre", {31'b0, err_unexpected_o}, 32'd0);
    d_valid_i = 1'b1;
    d_data_i  = 32'h5555_5555;
    #1;
    checkOutput("t5_d_ready", {31'b0, d_ready_o}, 32'd1);
    checkOutput("t5_no_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    tick();
    d_valid_i = 1'b0;
    d_data_i  = '0;
    #1;
    checkOutput("t5_sticky_set", {31'b0, err_unexpected_o}, 32'd1);
    checkOutput("t5_no_rvalid_late", {31'b0, data_rvalid_o}, 32'd0);
    tick();
    tick();
    checkOutput("t5_sticky_hold", {31'b0, err_unexpected_o}, 32'd1);
    checkOutput("t5_cnt", 32'(dut.cnt), 32'd0);

    // reset with two reads in flight
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0400, 32'h0, 1'b1);
    checkOutput("t6_gnt0", {31'b0, data_gnt_o}, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0404, 32'h0, 1'b1);
    checkOutput("t6_gnt1", {31'b0, data_gnt_o}, 32'd1);
    tick();
    checkOutput("t6_cnt2", 32'(dut.cnt), 32'd2);
    rst_i     = 1'b1;
    d_valid_i = 1'b1;
    d_data_i  = 32'h6666_6666;
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0408, 32'h0, 1'b1);
    checkOutput("t6_rst_a_valid", {31'b0, a_valid_o}, 32'd0);
    checkOutput("t6_rst_gnt", {31'b0, data_gnt_o}, 32'd0);
    checkOutput("t6_rst_d_ready", {31'b0, d_ready_o}, 32'd0);
    checkOutput("t6_rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    checkOutput("t6_rst_err", {31'b0, data_err_o}, 32'd0);
    checkOutput("t6_rst_rdata", data_rdata_o, 32'd0);
    checkOutput("t6_rst_sticky", {31'b0, err_unexpected_o}, 32'd0);
    tick();
    rst_i     = 1'b0;
    d_valid_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("t6_cnt_after", 32'(dut.cnt), 32'd0);
    checkOutput("t6_d_ready_idle", {31'b0, d_ready_o}, 32'd0);
    d_valid_i = 1'b1;
    #1;
    checkOutput("t6_stale_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    tick();
    d_valid_i = 1'b0;
    d_data_i  = '0;
    #1;
    checkOutput("t6_stale_sticky", {31'b0, err_unexpected_o}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h8000_0500, 32'h0, 1'b1);
    checkOutput("t6_fresh_gnt", {31'b0, data_gnt_o}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    respond(32'h7777_7777, 1'b0, 1'b0, "t6_r");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
